// File: rtl/seq_det_pkg.sv
// Shared definitions for the "1011" sequence detector with digit scan.
//   state_t    : Moore FSM state encoding (S_IDLE=0 .. S_HIT=4)
//   BLANK_CODE : digit value the seven-segment decoder renders as all-off
//   DIG_*      : digit slot indices (0 = rightmost digit)
//   cnt_inc    : decimal 0-9 wrapping increment for the detection count
package seq_det_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_HIT  = 3'd4
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [1:0] DIG_B0  = 2'd0;
  localparam logic [1:0] DIG_B1  = 2'd1;
  localparam logic [1:0] DIG_B2  = 2'd2;
  localparam logic [1:0] DIG_CNT = 2'd3;

  function automatic logic [3:0] cnt_inc(input logic [3:0] c);
    return (c == 4'd9) ? 4'd0 : c + 4'd1;
  endfunction

endpackage

// File: rtl/seq_det_scan_if.sv
// Bit-strobe input and digit-scan output bundle of seq_det_scan.
//   bit_vld : one-cycle strobe, bit_in carries a new serial bit
//   bit_in  : serial data bit
//   clr     : synchronous soft clear of FSM, history and count
//   sel     : digit select to decoder (0 = rightmost)
//   key     : value for the selected digit (0-9 or blank code)
//   det     : high while the FSM sits in S_HIT
// master = stimulus / key front-end side, slave = detector.
interface seq_det_scan_if;
  logic       bit_vld;
  logic       bit_in;
  logic       clr;
  logic [1:0] sel;
  logic [3:0] key;
  logic       det;

  modport master (
    output bit_vld, bit_in, clr,
    input  sel, key, det
  );

  modport slave (
    input  bit_vld, bit_in, clr,
    output sel, key, det
  );
endinterface

// File: rtl/seq_scan_timer.sv
// Digit-scan timebase: divides clk by SCAN_DIV and steps the digit select
// 0,1,2,3,0,... once per slot.
//   clk, rst : clock, synchronous active-high reset
//   sel      : current digit select
//   sel_nxt  : value sel takes at the next edge (lets the parent register
//              key in lock-step with sel)
module seq_scan_timer #(
  parameter int SCAN_DIV = 12000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] sel,
  output logic [1:0] sel_nxt
);
  import seq_det_pkg::*;

  localparam int                CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tc;

  assign tc      = (cnt == CNT_MAX);
  assign sel_nxt = tc ? sel + 2'd1 : sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sel <= DIG_B0;
    end else begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
      sel <= sel_nxt;
    end
  end

endmodule

// File: rtl/seq_det_scan.sv
// Serial "1011" sequence detector with built-in 4-digit scan sequencer.
// Digits 0-2 show the three most recent accepted bits (blank until filled),
// digit 3 shows the decimal detection count (wraps 9->0).
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_det_scan_if.slave (bit_vld, bit_in, clr in; sel, key, det out)
// Parameters: SCAN_DIV (clocks per digit slot, >= 2), BLANK_CODE.
// Build option: define SEQ_DET_OVERLAP_EN for overlapping detection
// (S_HIT on 0 -> S_10); default is non-overlapping (S_HIT on 0 -> S_IDLE).
module seq_det_scan #(
  parameter int         SCAN_DIV   = 12000,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input logic           clk,
  input logic           rst,
  seq_det_scan_if.slave bus
);
  import seq_det_pkg::*;

  state_t     state, state_nxt;
  logic [2:0] hist, hist_nxt;
  logic [2:0] hist_vld, hist_vld_nxt;
  logic [3:0] hit_cnt, hit_cnt_nxt;
  logic [3:0] key;
  logic       det;
  logic [1:0] sel, sel_nxt;

  seq_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .sel_nxt (sel_nxt)
  );

  function automatic state_t fsm_step(input state_t s, input logic b);
    case (s)
      S_IDLE:  return b ? S_1   : S_IDLE;
      S_1:     return b ? S_1   : S_10;
      S_10:    return b ? S_101 : S_IDLE;
      S_101:   return b ? S_HIT : S_10;
`ifdef SEQ_DET_OVERLAP_EN
      S_HIT:   return b ? S_1   : S_10;
`else
      S_HIT:   return b ? S_1   : S_IDLE;
`endif
      default: return S_IDLE;
    endcase
  endfunction

  function automatic logic [3:0] dig_val(input logic [1:0] s, input logic [2:0] h,
                                         input logic [2:0] hv, input logic [3:0] c);
    case (s)
      DIG_B0:  return hv[0] ? {3'b000, h[0]} : BLANK_CODE;
      DIG_B1:  return hv[1] ? {3'b000, h[1]} : BLANK_CODE;
      DIG_B2:  return hv[2] ? {3'b000, h[2]} : BLANK_CODE;
      DIG_CNT: return c;
      default: return BLANK_CODE;
    endcase
  endfunction

  // Next display/FSM content; clr wins over a simultaneous strobe.
  always_comb begin
    state_nxt    = state;
    hist_nxt     = hist;
    hist_vld_nxt = hist_vld;
    hit_cnt_nxt  = hit_cnt;
    if (bus.clr) begin
      state_nxt    = S_IDLE;
      hist_nxt     = '0;
      hist_vld_nxt = '0;
      hit_cnt_nxt  = '0;
    end else if (bus.bit_vld) begin
      state_nxt    = fsm_step(state, bus.bit_in);
      hist_nxt     = {hist[1:0], bus.bit_in};
      hist_vld_nxt = {hist_vld[1:0], 1'b1};
      if (state_nxt == S_HIT) hit_cnt_nxt = cnt_inc(hit_cnt);
    end
  end

  // Registered state and outputs; key looks at next-cycle sel and content so
  // that a slot change or content change shows on the edge that commits it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hist     <= '0;
      hist_vld <= '0;
      hit_cnt  <= '0;
      det      <= 1'b0;
      key      <= BLANK_CODE;
    end else begin
      state    <= state_nxt;
      hist     <= hist_nxt;
      hist_vld <= hist_vld_nxt;
      hit_cnt  <= hit_cnt_nxt;
      det      <= (state_nxt == S_HIT);
      key      <= dig_val(sel_nxt, hist_nxt, hist_vld_nxt, hit_cnt_nxt);
    end
  end

  assign bus.sel = sel;
  assign bus.key = key;
  assign bus.det = det;

endmodule
